sms_timing_ring: RTL and testbench

- Memory-cycle timing ring driven by the 1 MHz SMS oscillator card output.
- Divides the oscillator into a one-hot ring of timing positions T0..T(RING_LEN-1), each held for SUB_STEPS oscillator periods. With the defaults this gives 10 positions x 2 us = one 20 us memory cycle.
- Provides start, stop and single-cycle control, cycle boundary pulses and a completed-cycle counter to downstream gate and memory-control logic.

---
 rtl/sms_timing_ring.sv | 133 +++++++++++++
 tb/tb_sms_timing_ring.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sms_timing_ring.sv
// Memory-cycle timing ring: divides the SMS oscillator into a one-hot ring of
// timing positions, with start/stop/single-cycle control and a cycle counter.
module sms_timing_ring #(
    parameter int RING_LEN    = 10,
    parameter int SUB_STEPS   = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   single_cycle,
    output logic [RING_LEN-1:0]    t,
    output logic                   phase,
    output logic                   cycle_start,
    output logic                   cycle_end,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] cycle_count
);
    // state    | meaning
    // IDLE     | ring stopped, t = 0
    // RUN      | ring advancing
    // STOPPING | ring advancing, halts on the edge after cycle_end
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam int SUB_W = (SUB_STEPS > 1) ? $clog2(SUB_STEPS) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SUB_STEPS - 1);
    localparam logic [SUB_W:0]   PHASE_LIM = (SUB_W + 1)'(SUB_STEPS - SUB_STEPS / 2);

    state_t                 state_q, state_d;
    logic [RING_LEN-1:0]    t_q, t_d;
    logic [SUB_W-1:0]       rem_q, rem_d;
    logic                   phase_q, phase_d;
    logic                   cycle_start_q, cycle_start_d;
    logic                   cycle_end_q, cycle_end_d;
    logic                   running_q, running_d;
    logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic                   stop_pending_q, stop_pending_d;
    logic                   single_q, single_d;
    logic [RING_LEN-1:0]    t_rot;

    assign t_rot = {t_q[RING_LEN-2:0], t_q[RING_LEN-1]};

    // The sub-step timer counts down; rem = SUB_STEPS-1-sub, terminal count at 0.
    always_comb begin
        state_d        = state_q;
        t_d            = t_q;
        rem_d          = rem_q;
        cycle_count_d  = cycle_count_q;
        stop_pending_d = stop_pending_q;
        single_d       = single_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = stop ? STOPPING : RUN;
                    stop_pending_d = stop;
                    single_d       = single_cycle;
                    t_d            = RING_LEN'(1);
                    rem_d          = SUB_LAST;
                end
            end
            RUN, STOPPING: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - SUB_W'(1);
                end else if (cycle_end_q && (stop_pending_q || single_q)) begin
                    cycle_count_d  = cycle_count_q + COUNT_WIDTH'(1);
                    state_d        = IDLE;
                    t_d            = '0;
                    rem_d          = '0;
                    stop_pending_d = 1'b0;
                    single_d       = 1'b0;
                end else begin
                    if (cycle_end_q) begin
                        cycle_count_d = cycle_count_q + COUNT_WIDTH'(1);
                    end
                    t_d   = t_rot;
                    rem_d = SUB_LAST;
                end
                // A stop on the wrap edge belongs to the cycle that is just starting.
                if (stop && state_d != IDLE) begin
                    state_d        = STOPPING;
                    stop_pending_d = 1'b1;
                end
            end
            default: begin
                state_d        = IDLE;
                t_d            = '0;
                rem_d          = '0;
                stop_pending_d = 1'b0;
                single_d       = 1'b0;
            end
        endcase

        running_d     = (t_d != '0);
        cycle_start_d = t_d[0] && (rem_d == SUB_LAST);
        cycle_end_d   = t_d[RING_LEN-1] && (rem_d == '0);
        phase_d       = running_d && ({1'b0, rem_d} < PHASE_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            t_q            <= '0;
            rem_q          <= '0;
            phase_q        <= 1'b0;
            cycle_start_q  <= 1'b0;
            cycle_end_q    <= 1'b0;
            running_q      <= 1'b0;
            cycle_count_q  <= '0;
            stop_pending_q <= 1'b0;
            single_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            t_q            <= t_d;
            rem_q          <= rem_d;
            phase_q        <= phase_d;
            cycle_start_q  <= cycle_start_d;
            cycle_end_q    <= cycle_end_d;
            running_q      <= running_d;
            cycle_count_q  <= cycle_count_d;
            stop_pending_q <= stop_pending_d;
            single_q       <= single_d;
        end
    end

    assign t           = t_q;
    assign phase       = phase_q;
    assign cycle_start = cycle_start_q;
    assign cycle_end   = cycle_end_q;
    assign running     = running_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sms_timing_ring.sv
// Bench for sms_timing_ring: directed table, cycle-position reference model
// feeding a scoreboard queue, and hand-checked multi-cycle corner cases.
module tb_sms_timing_ring;
    localparam int RING_LEN  = 10;
    localparam int SUB_STEPS = 2;
    localparam int CYC       = RING_LEN * SUB_STEPS;

    logic clk = 1'b0;
    logic reset, start, stop, single_cycle;
    logic [RING_LEN-1:0] t_o, t4_o;
    logic phase_o, cs_o, ce_o, run_o;
    logic phase4_o, cs4_o, ce4_o, run4_o;
    logic [15:0] cnt_o;
    logic [3:0]  cnt4_o;

    always #5 clk = ~clk;

    sms_timing_ring dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .single_cycle(single_cycle),
        .t(t_o), .phase(phase_o), .cycle_start(cs_o), .cycle_end(ce_o),
        .running(run_o), .cycle_count(cnt_o)
    );

    sms_timing_ring #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .single_cycle(single_cycle),
        .t(t4_o), .phase(phase4_o), .cycle_start(cs4_o), .cycle_end(ce4_o),
        .running(run4_o), .cycle_count(cnt4_o)
    );

    typedef struct {
        logic rst, st, sp, sc;
        logic [RING_LEN-1:0] t;
        logic ph, cs, ce, run;
        logic [15:0] cnt;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[8];
    int n_vec  = 0;
    int n_miss = 0;

    // Reference model tracks the clock index within the 20-clock cycle.
    bit          m_act, m_stop, m_single;
    int          m_pos;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic p, input logic sc);
        if (r) begin
            m_act = 0; m_pos = 0; m_stop = 0; m_single = 0; m_cnt = '0;
        end else if (!m_act) begin
            if (s) begin
                m_act = 1; m_pos = 0; m_stop = p; m_single = sc;
            end
        end else if (m_pos == CYC - 1) begin
            m_cnt = m_cnt + 16'd1;
            if (m_stop || m_single) begin
                m_act = 0; m_pos = 0; m_stop = 0; m_single = 0;
            end else begin
                m_pos = 0;
                if (p) m_stop = 1;
            end
        end else begin
            m_pos++;
            if (p) m_stop = 1;
        end
    endtask

    function automatic vec_t model_exp();
        vec_t e;
        e.rst = 0; e.st = 0; e.sp = 0; e.sc = 0;
        e.t   = m_act ? (RING_LEN'(1) << (m_pos / SUB_STEPS)) : '0;
        e.ph  = m_act && ((m_pos % SUB_STEPS) >= SUB_STEPS / 2);
        e.cs  = m_act && (m_pos == 0);
        e.ce  = m_act && (m_pos == CYC - 1);
        e.run = m_act;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic check_out();
        vec_t e;
        e = sb_q.pop_front();
        check("t", 32'(t_o), 32'(e.t));
        check("phase", 32'(phase_o), 32'(e.ph));
        check("cycle_start", 32'(cs_o), 32'(e.cs));
        check("cycle_end", 32'(ce_o), 32'(e.ce));
        check("running", 32'(run_o), 32'(e.run));
        check("cycle_count", 32'(cnt_o), 32'(e.cnt));
        check("t_w4", 32'(t4_o), 32'(e.t));
        check("flags_w4", 32'({phase4_o, cs4_o, ce4_o, run4_o}), 32'({e.ph, e.cs, e.ce, e.run}));
        check("cycle_count_w4", 32'(cnt4_o), 32'(e.cnt[3:0]));
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic sc);
        reset = r; start = s; stop = p; single_cycle = sc;
        model_step(r, s, p, sc);
    endtask

    task automatic cycle(input logic r, input logic s, input logic p, input logic sc);
        drive(r, s, p, sc);
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.rst, v.st, v.sp, v.sc);
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        int n_run, n_cs, n_ce, n_idle, ce_at, k, wraps, bad_onehot, bad_phase;
        logic prev_run, prev_ph;
        logic [3:0] prev_c4;

        //          rst st sp sc  t        ph cs ce run cnt
        tbl[0] = '{1, 0, 0, 0, 10'h000, 0, 0, 0, 0, 16'd0};
        tbl[1] = '{0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 16'd0};
        tbl[2] = '{0, 0, 1, 0, 10'h000, 0, 0, 0, 0, 16'd0};
        tbl[3] = '{0, 1, 0, 0, 10'h001, 0, 1, 0, 1, 16'd0};
        tbl[4] = '{0, 0, 0, 0, 10'h001, 1, 0, 0, 1, 16'd0};
        tbl[5] = '{0, 0, 0, 0, 10'h002, 0, 0, 0, 1, 16'd0};
        tbl[6] = '{0, 0, 0, 0, 10'h002, 1, 0, 0, 1, 16'd0};
        tbl[7] = '{0, 1, 0, 0, 10'h004, 0, 0, 0, 1, 16'd0};

        reset = 1; start = 0; stop = 0; single_cycle = 0;
        m_act = 0; m_stop = 0; m_single = 0; m_pos = 0; m_cnt = '0;
        #1;

        // Basic free-running cycle; stop while idle must not be latched.
        for (int i = 0; i < 8; i++) apply_vec(tbl[i]);
        for (int i = 6; i <= CYC; i++) begin
            cycle(0, 0, 0, 0);
            if (i == CYC) begin
                check("end_clk20_ce", 32'(ce_o), 32'd1);
                check("end_clk20_t9", 32'(t_o), 32'h200);
            end
        end
        cycle(0, 0, 0, 0);
        check("wrap_t0", 32'(t_o), 32'h001);
        check("wrap_cs", 32'(cs_o), 32'd1);
        check("wrap_cnt", 32'(cnt_o), 32'd1);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 25; i++) cycle(0, 0, 0, 0);
        check("stopped_idle", 32'(run_o), 32'd0);

        // Single-cycle run, then 50 idle clocks.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 1);
        n_run = 0; n_ce = 0;
        for (int i = 0; i < 70; i++) begin
            if (i > 0) cycle(0, 0, 0, 0);
            if (run_o) n_run++;
            if (ce_o) n_ce++;
        end
        check("single_run_clks", 32'(n_run), 32'd20);
        check("single_ce_cnt", 32'(n_ce), 32'd1);
        check("single_cnt", 32'(cnt_o), 32'd1);
        check("single_t_idle", 32'(t_o), 32'd0);

        // Stop pulsed in T3 lets the cycle finish.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        k = 0;
        while (t_o != 10'h008 && k < 30) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        check("reach_t3", 32'(t_o), 32'h008);
        cycle(0, 0, 1, 0);
        n_cs = 0; n_ce = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 0);
            if (cs_o) n_cs++;
            if (ce_o) n_ce++;
        end
        check("stop_ce", 32'(n_ce), 32'd1);
        check("stop_no_cs", 32'(n_cs), 32'd0);
        check("stop_cnt", 32'(cnt_o), 32'd1);
        check("stop_idle", 32'(run_o), 32'd0);

        // Reset during T5 second half.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        k = 0;
        while (!(t_o == 10'h020 && phase_o) && k < 30) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        check("reach_t5_ph1", 32'({t_o, phase_o}), 32'({10'h020, 1'b1}));
        cycle(1, 0, 0, 0);
        check("rst_mid_outs", 32'({t_o, phase_o, cs_o, ce_o, run_o}), 32'd0);
        check("rst_mid_cnt", 32'(cnt_o), 32'd0);
        cycle(0, 1, 0, 0);
        check("restart_t0", 32'({t_o, cs_o}), 32'({10'h001, 1'b1}));
        check("restart_cnt", 32'(cnt_o), 32'd0);

        // Start held for 17 cycles: 4-bit counter wraps.
        cycle(1, 0, 0, 0);
        n_ce = 0; wraps = 0; bad_onehot = 0; bad_phase = 0;
        prev_run = 0; prev_ph = 0; prev_c4 = 4'd0;
        for (int i = 0; i < 17 * CYC + 1; i++) begin
            cycle(0, 1, 0, 0);
            if (ce_o) n_ce++;
            if (!$onehot0(t_o) || (run_o != (t_o != '0))) bad_onehot++;
            if (prev_run && run_o && (phase_o == prev_ph)) bad_phase++;
            if (prev_c4 == 4'd15 && cnt4_o == 4'd0) wraps++;
            prev_run = run_o; prev_ph = phase_o; prev_c4 = cnt4_o;
        end
        check("held_ce", 32'(n_ce), 32'd17);
        check("held_wrap15to0", 32'(wraps), 32'd1);
        check("held_cnt4", 32'(cnt4_o), 32'd1);
        check("held_cnt16", 32'(cnt_o), 32'd17);
        check("held_onehot", 32'(bad_onehot), 32'd0);
        check("held_phase_toggle", 32'(bad_phase), 32'd0);
        cycle(0, 1, 1, 0);
        n_idle = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 0, 0);
            if (!run_o) n_idle++;
        end
        check("held_idle_one_clk", 32'(n_idle), 32'd1);

        // Start and stop on the same idle edge; start during RUN ignored.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        n_run = 0; n_cs = 0; n_ce = 0; ce_at = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) cycle(0, (i == 5) ? 1'b1 : 1'b0, 0, 0);
            if (run_o) n_run++;
            if (cs_o) n_cs++;
            if (ce_o) begin
                n_ce++;
                ce_at = i;
            end
        end
        check("ss_run_clks", 32'(n_run), 32'd20);
        check("ss_cs", 32'(n_cs), 32'd1);
        check("ss_ce", 32'(n_ce), 32'd1);
        check("ss_ce_clk", 32'(ce_at), 32'd20);
        check("ss_final_idle", 32'(t_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
